// File: rtl/axi_trace_pkg.sv
// Shared types for the AXI4-Lite trace monitor: entry layout, kind and FSM encodings.
// AXI_TRACE_TIMESTAMP_EN adds a 32-bit cycle stamp to each entry.
package axi_trace_pkg;

   localparam int TRC_ADDR_W = 32;
   localparam int TRC_DATA_W = 32;
   localparam int TRC_STRB_W = TRC_DATA_W / 8;
   localparam int DROP_W     = 16;
   localparam int TS_W       = 32;

   typedef enum logic {
      TRC_WR = 1'b0,
      TRC_RD = 1'b1
   } trc_kind_e;

   typedef enum logic [1:0] {
      W_IDLE   = 2'd0,
      W_GOT_A  = 2'd1,
      W_GOT_D  = 2'd2,
      W_WAIT_B = 2'd3
   } wr_state_e;

   typedef enum logic {
      R_IDLE   = 1'b0,
      R_WAIT_R = 1'b1
   } rd_state_e;

   typedef struct packed {
      trc_kind_e               kind;
      logic [TRC_ADDR_W-1:0]   addr;
      logic [TRC_DATA_W-1:0]   data;
      logic [TRC_STRB_W-1:0]   strb;
`ifdef AXI_TRACE_TIMESTAMP_EN
      logic [TS_W-1:0]         ts;
`endif
   } trc_entry_t;

endpackage

// File: rtl/axi_trace_fifo.sv
// Synchronous first-word-fall-through FIFO of trace entries; pointers carry one wrap bit.
module axi_trace_fifo
   import axi_trace_pkg::*;
#(
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        push,
   input  logic        pop,
   input  logic        clr,
   input  trc_entry_t  push_entry,
   output trc_entry_t  head,
   output logic [AW:0] count,
   output logic        full,
   output logic        empty
);

   trc_entry_t  mem_r [DEPTH];
   logic [AW:0] wr_ptr_r;
   logic [AW:0] rd_ptr_r;
   logic        do_push_s;
   logic        do_pop_s;

   assign empty     = (wr_ptr_r == rd_ptr_r);
   assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign do_pop_s  = pop & ~empty;
   // A pop in the same cycle frees the slot a push into a full FIFO needs.
   assign do_push_s = push & (~full | do_pop_s);
   assign count     = wr_ptr_r - rd_ptr_r;
   assign head      = mem_r[rd_ptr_r[AW-1:0]];

   // Storage and pointer update; clear empties the FIFO ahead of any push/pop.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (clr) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_entry;
            wr_ptr_r                <= wr_ptr_r + (AW+1)'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/axi_lite_trace_capture.sv
// Passive AXI4-Lite monitor recording completed writes and reads into a drainable FIFO.
// Define AXI_TRACE_TIMESTAMP_EN to stamp entries with a free-running cycle count (trc_ts).
module axi_lite_trace_capture
   import axi_trace_pkg::*;
#(
   parameter  int ADDR_W = TRC_ADDR_W,
   parameter  int DATA_W = TRC_DATA_W,
   parameter  int DEPTH  = 16,
   localparam int STRB_W = DATA_W / 8,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              s_axi_awvalid,
   input  logic              s_axi_awready,
   input  logic [ADDR_W-1:0] s_axi_awaddr,
   input  logic              s_axi_wvalid,
   input  logic              s_axi_wready,
   input  logic [DATA_W-1:0] s_axi_wdata,
   input  logic [STRB_W-1:0] s_axi_wstrb,
   input  logic              s_axi_bvalid,
   input  logic              s_axi_bready,
   input  logic              s_axi_arvalid,
   input  logic              s_axi_arready,
   input  logic [ADDR_W-1:0] s_axi_araddr,
   input  logic              s_axi_rvalid,
   input  logic              s_axi_rready,
   input  logic [DATA_W-1:0] s_axi_rdata,
   input  logic              trc_pop,
   input  logic              trc_clr,
   output logic              trc_valid,
   output logic              trc_kind,
   output logic [ADDR_W-1:0] trc_addr,
   output logic [DATA_W-1:0] trc_data,
   output logic [STRB_W-1:0] trc_strb,
   output logic [AW:0]       trc_count,
   output logic              trc_ovf,
`ifdef AXI_TRACE_TIMESTAMP_EN
   output logic [TS_W-1:0]   trc_ts,
`endif
   output logic [DROP_W-1:0] trc_drop_cnt
);

   wr_state_e         w_state_r;
   rd_state_e         r_state_r;
   logic [ADDR_W-1:0] w_addr_r;
   logic [DATA_W-1:0] w_data_r;
   logic [STRB_W-1:0] w_strb_r;
   logic [ADDR_W-1:0] r_addr_r;
   trc_entry_t        pend_r;
   logic              pend_valid_r;
   logic [TS_W-1:0]   ts_r;

   logic aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
   logic wr_push_s, rd_push_s;
   logic fifo_push_s, fifo_full_s, fifo_empty_s, drop_s;
   trc_entry_t wr_entry_s, rd_entry_s, fifo_entry_s, head_s;

   assign aw_hs_s   = s_axi_awvalid & s_axi_awready;
   assign w_hs_s    = s_axi_wvalid & s_axi_wready;
   assign b_hs_s    = s_axi_bvalid & s_axi_bready;
   assign ar_hs_s   = s_axi_arvalid & s_axi_arready;
   assign r_hs_s    = s_axi_rvalid & s_axi_rready;
   assign wr_push_s = (w_state_r == W_WAIT_B) & b_hs_s;
   assign rd_push_s = (r_state_r == R_WAIT_R) & r_hs_s;

   // Write-side tracker: collects address and data in either order, completes on b.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         w_state_r <= W_IDLE;
         w_addr_r  <= '0;
         w_data_r  <= '0;
         w_strb_r  <= '0;
      end else begin
         if (aw_hs_s && (w_state_r == W_IDLE || w_state_r == W_GOT_D)) begin
            w_addr_r <= s_axi_awaddr;
         end
         if (w_hs_s && (w_state_r == W_IDLE || w_state_r == W_GOT_A)) begin
            w_data_r <= s_axi_wdata;
            w_strb_r <= s_axi_wstrb;
         end
         case (w_state_r)
            W_IDLE: begin
               if (aw_hs_s && w_hs_s) w_state_r <= W_WAIT_B;
               else if (aw_hs_s)      w_state_r <= W_GOT_A;
               else if (w_hs_s)       w_state_r <= W_GOT_D;
            end
            W_GOT_A:  if (w_hs_s)  w_state_r <= W_WAIT_B;
            W_GOT_D:  if (aw_hs_s) w_state_r <= W_WAIT_B;
            W_WAIT_B: if (b_hs_s)  w_state_r <= W_IDLE;
            default:  w_state_r <= W_IDLE;
         endcase
      end
   end

   // Read-side tracker: latch the address on ar, complete on r.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state_r <= R_IDLE;
         r_addr_r  <= '0;
      end else begin
         case (r_state_r)
            R_IDLE: begin
               if (ar_hs_s) begin
                  r_addr_r  <= s_axi_araddr;
                  r_state_r <= R_WAIT_R;
               end
            end
            R_WAIT_R: if (r_hs_s) r_state_r <= R_IDLE;
            default:  r_state_r <= R_IDLE;
         endcase
      end
   end

   // Entry assembly and push arbitration: write first, then a pended read, then a fresh read.
   always_comb begin
      wr_entry_s      = '0;
      wr_entry_s.kind = TRC_WR;
      wr_entry_s.addr = w_addr_r;
      wr_entry_s.data = w_data_r;
      wr_entry_s.strb = w_strb_r;
      rd_entry_s      = '0;
      rd_entry_s.kind = TRC_RD;
      rd_entry_s.addr = r_addr_r;
      rd_entry_s.data = s_axi_rdata;
      rd_entry_s.strb = {STRB_W{1'b1}};
`ifdef AXI_TRACE_TIMESTAMP_EN
      wr_entry_s.ts   = ts_r;
      rd_entry_s.ts   = ts_r;
`endif
      fifo_push_s  = 1'b0;
      fifo_entry_s = '0;
      if (wr_push_s) begin
         fifo_push_s  = 1'b1;
         fifo_entry_s = wr_entry_s;
      end else if (pend_valid_r) begin
         fifo_push_s  = 1'b1;
         fifo_entry_s = pend_r;
      end else if (rd_push_s) begin
         fifo_push_s  = 1'b1;
         fifo_entry_s = rd_entry_s;
      end else begin
         fifo_push_s  = 1'b0;
      end
   end

   // One-deep holding slot for a read that lost arbitration.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pend_r       <= '0;
         pend_valid_r <= 1'b0;
      end else if (trc_clr) begin
         pend_valid_r <= 1'b0;
      end else if (rd_push_s && (wr_push_s || pend_valid_r)) begin
         pend_r       <= rd_entry_s;
         pend_valid_r <= 1'b1;
      end else if (pend_valid_r && !wr_push_s) begin
         pend_valid_r <= 1'b0;
      end
   end

   assign drop_s = fifo_push_s & fifo_full_s & ~trc_pop & ~trc_clr;

   // Sticky overflow flag and saturating drop counter.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         trc_ovf      <= 1'b0;
         trc_drop_cnt <= '0;
      end else if (trc_clr) begin
         trc_ovf      <= 1'b0;
         trc_drop_cnt <= '0;
      end else if (drop_s) begin
         trc_ovf <= 1'b1;
         if (trc_drop_cnt != {DROP_W{1'b1}}) begin
            trc_drop_cnt <= trc_drop_cnt + DROP_W'(1);
         end
      end
   end

`ifdef AXI_TRACE_TIMESTAMP_EN
   // Free-running cycle stamp; unaffected by trc_clr.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) ts_r <= '0;
      else       ts_r <= ts_r + TS_W'(1);
   end
   assign trc_ts = head_s.ts;
`else
   assign ts_r = '0;
`endif

   axi_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rstn       (rstn),
      .push       (fifo_push_s),
      .pop        (trc_pop),
      .clr        (trc_clr),
      .push_entry (fifo_entry_s),
      .head       (head_s),
      .count      (trc_count),
      .full       (fifo_full_s),
      .empty      (fifo_empty_s)
   );

   assign trc_valid = ~fifo_empty_s;
   assign trc_kind  = head_s.kind;
   assign trc_addr  = head_s.addr;
   assign trc_data  = head_s.data;
   assign trc_strb  = head_s.strb;

endmodule
